// File: rtl/rvv_arb_pkg.sv
// ---------------------------------------------------------------------------
// rvv_arb_pkg
// Shared types and defaults for the two-requester vector memory arbiter.
//   NUM_REQ         number of requesters sharing the mem_queue rvv port
//   DEF_DATA_WIDTH  default width of one vector memory data beat
//   DEF_ADDR_WIDTH  default byte address width
//   PERF_CNT_WIDTH  width of each performance counter
//   arb_state_t     IDLE (no owner), LD_OWN (owner runs a load),
//                   ST_OWN (owner runs a store)
// ---------------------------------------------------------------------------
package rvv_arb_pkg;

    localparam int NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int PERF_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_OWN = 2'd1,
        ST_OWN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rvv_mem_arb_if.sv
// ---------------------------------------------------------------------------
// rvv_mem_arb_if
// One rvv memory port bundle, used both for each requester and for the
// shared mem_queue side.
//   req / start   load / store request (held until gnt on requester side)
//   addr          transaction address / beat address
//   data, valid,  store beat data, beat valid and byte enables
//   be
//   gnt           port ownership level (requester side only)
//   rdata, rvalid load data and beat valid
//   done_ld,      load / store completion pulses
//   done_st
// Modports:
//   master  requester client (drives the request fields)
//   slave   arbiter facing a requester (drives gnt and the return fields)
//   mem     arbiter facing mem_queue (no grant on that side)
// ---------------------------------------------------------------------------
interface rvv_mem_arb_if
    import rvv_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DW_B       = DATA_WIDTH / 8
);

    logic                  req;
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic [DW_B-1:0]       be;
    logic                  gnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  done_ld;
    logic                  done_st;

    modport master (
        output req, start, addr, data, valid, be,
        input  gnt, rdata, rvalid, done_ld, done_st
    );

    modport slave (
        input  req, start, addr, data, valid, be,
        output gnt, rdata, rvalid, done_ld, done_st
    );

    modport mem (
        output req, start, addr, data, valid, be,
        input  rdata, rvalid, done_ld, done_st
    );

endinterface

// File: rtl/rvv_arb_perf_cnt.sv
// ---------------------------------------------------------------------------
// rvv_arb_perf_cnt
// One saturating 32-bit event counter.
//   clk    sole clock
//   rst_n  asynchronous active-low reset, clears the count
//   inc    count one event this cycle
//   count  current count, sticks at all-ones
// Only compiled when RVV_ARB_PERF_EN is defined, so the default build
// contains no counter logic at all.
// ---------------------------------------------------------------------------
`ifdef RVV_ARB_PERF_EN
module rvv_arb_perf_cnt
    import rvv_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    output logic [PERF_CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {PERF_CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/rvv_mem_arb.sv
// ---------------------------------------------------------------------------
// rvv_mem_arb
// Round-robin arbiter sharing the single mem_queue rvv port between two
// vector memory clients. One whole load or store is granted at a time; the
// grant is held until mem_queue reports the matching done.
//   clk              sole clock
//   rst_n            asynchronous active-low reset
//   rq0, rq1         requester ports (slave modport)
//   mq               mem_queue port (mem modport)
//   perf_gnt_cnt_*   grants issued to each requester
//   perf_wait_cnt_*  cycles each requester waited while pending
// Optional feature macro: RVV_ARB_PERF_EN builds the performance counters;
// without it the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module rvv_mem_arb
    import rvv_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DW_B       = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rvv_mem_arb_if.slave              rq0,
    rvv_mem_arb_if.slave              rq1,
    rvv_mem_arb_if.mem                mq,
    output logic [PERF_CNT_WIDTH-1:0] perf_gnt_cnt_0,
    output logic [PERF_CNT_WIDTH-1:0] perf_gnt_cnt_1,
    output logic [PERF_CNT_WIDTH-1:0] perf_wait_cnt_0,
    output logic [PERF_CNT_WIDTH-1:0] perf_wait_cnt_1
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  owner;
    logic                  owner_next;
    logic                  rr_ptr;
    logic                  rr_next;
    logic                  pend_0;
    logic                  pend_1;
    logic                  winner;
    logic                  gnt_0;
    logic                  gnt_1;
    logic                  own_req;
    logic                  own_start;
    logic                  own_valid;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_data;
    logic [DW_B-1:0]       own_be;

    assign pend_0 = rq0.req | rq0.start;
    assign pend_1 = rq1.req | rq1.start;

    // With a single pending requester it wins outright; the round-robin
    // pointer only breaks a tie.
    assign winner = (pend_0 && pend_1) ? rr_ptr : pend_1;

    assign own_req   = owner ? rq1.req   : rq0.req;
    assign own_start = owner ? rq1.start : rq0.start;
    assign own_valid = owner ? rq1.valid : rq0.valid;
    assign own_addr  = owner ? rq1.addr  : rq0.addr;
    assign own_data  = owner ? rq1.data  : rq0.data;
    assign own_be    = owner ? rq1.be    : rq0.be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_next;
        end
    end

    // A load request wins over a simultaneous store request from the same
    // client. Only a done of the running transaction type releases the port.
    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        case (state)
            IDLE: begin
                if (pend_0 || pend_1) begin
                    owner_next = winner;
                    state_next = (winner ? rq1.req : rq0.req) ? LD_OWN : ST_OWN;
                end
            end
            LD_OWN: begin
                if (mq.done_ld) begin
                    state_next = IDLE;
                    rr_next    = ~owner;
                end
            end
            ST_OWN: begin
                if (mq.done_st) begin
                    state_next = IDLE;
                    rr_next    = ~owner;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The mem_queue side is a purely combinational copy of the owner, so a
    // reset or release forces it quiet in the same cycle.
    always_comb begin
        mq.req      = 1'b0;
        mq.start    = 1'b0;
        mq.valid    = 1'b0;
        mq.addr     = '0;
        mq.data     = '0;
        mq.be       = '0;
        gnt_0       = 1'b0;
        gnt_1       = 1'b0;
        rq0.rvalid  = 1'b0;
        rq1.rvalid  = 1'b0;
        rq0.done_ld = 1'b0;
        rq1.done_ld = 1'b0;
        rq0.done_st = 1'b0;
        rq1.done_st = 1'b0;
        if (state != IDLE) begin
            mq.req      = own_req;
            mq.start    = own_start;
            mq.valid    = own_valid;
            mq.addr     = own_addr;
            mq.data     = own_data;
            mq.be       = own_be;
            gnt_0       = ~owner;
            gnt_1       = owner;
            rq0.rvalid  = ~owner & mq.rvalid;
            rq1.rvalid  = owner & mq.rvalid;
            rq0.done_ld = ~owner & (state == LD_OWN) & mq.done_ld;
            rq1.done_ld = owner & (state == LD_OWN) & mq.done_ld;
            rq0.done_st = ~owner & (state == ST_OWN) & mq.done_st;
            rq1.done_st = owner & (state == ST_OWN) & mq.done_st;
        end
    end

    assign rq0.gnt   = gnt_0;
    assign rq1.gnt   = gnt_1;
    assign rq0.rdata = mq.rdata;
    assign rq1.rdata = mq.rdata;

`ifdef RVV_ARB_PERF_EN
    logic grant_evt;

    assign grant_evt = (state == IDLE) & (pend_0 | pend_1);

    rvv_arb_perf_cnt u_gnt_cnt_0 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_evt & ~winner),
        .count (perf_gnt_cnt_0)
    );

    rvv_arb_perf_cnt u_gnt_cnt_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_evt & winner),
        .count (perf_gnt_cnt_1)
    );

    rvv_arb_perf_cnt u_wait_cnt_0 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pend_0 & ~gnt_0),
        .count (perf_wait_cnt_0)
    );

    rvv_arb_perf_cnt u_wait_cnt_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pend_1 & ~gnt_1),
        .count (perf_wait_cnt_1)
    );
`else
    assign perf_gnt_cnt_0  = '0;
    assign perf_gnt_cnt_1  = '0;
    assign perf_wait_cnt_0 = '0;
    assign perf_wait_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_rvv_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_rvv_mem_arb
// Self-checking bench for rvv_mem_arb: directed scenarios (single load,
// wrong-type done, simultaneous requests, fairness, reset mid-store) and a
// randomized phase checked against a transaction-level ownership model.
// ---------------------------------------------------------------------------
module tb_rvv_mem_arb;
    import rvv_arb_pkg::*;

`ifdef RVV_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        req_v   [NUM_REQ];
    logic        start_v [NUM_REQ];
    logic        valid_v [NUM_REQ];
    logic [31:0] addr_v  [NUM_REQ];
    logic [63:0] data_v  [NUM_REQ];
    logic [7:0]  be_v    [NUM_REQ];

    logic        mq_rvalid_v  = 1'b0;
    logic        mq_done_ld_v = 1'b0;
    logic        mq_done_st_v = 1'b0;
    logic [63:0] mq_rdata_v   = '0;

    logic [31:0] perf_gnt_cnt_0;
    logic [31:0] perf_gnt_cnt_1;
    logic [31:0] perf_wait_cnt_0;
    logic [31:0] perf_wait_cnt_1;

    int checks = 0;
    int errors = 0;

    // Model of who owns the port, what kind of transaction it runs, who is
    // preferred on a tie, and the event counts the perf counters should show.
    int          m_owner;
    bit          m_is_ld;
    int          m_pref;
    int unsigned m_gnt  [NUM_REQ];
    int unsigned m_wait [NUM_REQ];

    rvv_mem_arb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) rq0_if ();
    rvv_mem_arb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) rq1_if ();
    rvv_mem_arb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) mq_if ();

    assign rq0_if.req   = req_v[0];
    assign rq0_if.start = start_v[0];
    assign rq0_if.valid = valid_v[0];
    assign rq0_if.addr  = addr_v[0];
    assign rq0_if.data  = data_v[0];
    assign rq0_if.be    = be_v[0];
    assign rq1_if.req   = req_v[1];
    assign rq1_if.start = start_v[1];
    assign rq1_if.valid = valid_v[1];
    assign rq1_if.addr  = addr_v[1];
    assign rq1_if.data  = data_v[1];
    assign rq1_if.be    = be_v[1];

    assign mq_if.rdata   = mq_rdata_v;
    assign mq_if.rvalid  = mq_rvalid_v;
    assign mq_if.done_ld = mq_done_ld_v;
    assign mq_if.done_st = mq_done_st_v;
    assign mq_if.gnt     = 1'b0;

    rvv_mem_arb #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rq0             (rq0_if),
        .rq1             (rq1_if),
        .mq              (mq_if),
        .perf_gnt_cnt_0  (perf_gnt_cnt_0),
        .perf_gnt_cnt_1  (perf_gnt_cnt_1),
        .perf_wait_cnt_0 (perf_wait_cnt_0),
        .perf_wait_cnt_1 (perf_wait_cnt_1)
    );

    always #5 clk = ~clk;

    // Ownership model: free port goes to a pending client (the preferred one
    // on a tie); the owner keeps it until a done of its own kind arrives.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_is_ld = 1'b0;
            m_pref  = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                m_gnt[i]  = 0;
                m_wait[i] = 0;
            end
        end else begin
            bit p [NUM_REQ];
            for (int i = 0; i < NUM_REQ; i++) begin
                p[i] = req_v[i] | start_v[i];
                if (p[i] && (m_owner != i) && (m_wait[i] != 32'hFFFF_FFFF))
                    m_wait[i] = m_wait[i] + 1;
            end
            if (m_owner < 0) begin
                if (p[0] || p[1]) begin
                    int w;
                    w = (p[0] && p[1]) ? m_pref : (p[0] ? 0 : 1);
                    m_owner = w;
                    m_is_ld = req_v[w];
                    if (m_gnt[w] != 32'hFFFF_FFFF) m_gnt[w] = m_gnt[w] + 1;
                end
            end else if ((m_is_ld && mq_done_ld_v) || (!m_is_ld && mq_done_st_v)) begin
                m_pref  = 1 - m_owner;
                m_owner = -1;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic ld, input logic st, input logic vld,
                                 input logic [31:0] a, input logic [63:0] d, input logic [7:0] b);
        req_v[i]   = ld;
        start_v[i] = st;
        valid_v[i] = vld;
        addr_v[i]  = a;
        data_v[i]  = d;
        be_v[i]    = b;
    endtask

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleOut();
        @(negedge clk);
    endtask

    task automatic checkAgainstModel(input string pfx);
        bit own;
        int o;
        own = (m_owner >= 0);
        o   = own ? m_owner : 0;
        checkOutput({pfx, "_gnt0"}, rq0_if.gnt, m_owner == 0);
        checkOutput({pfx, "_gnt1"}, rq1_if.gnt, m_owner == 1);
        checkOutput({pfx, "_rvalid0"}, rq0_if.rvalid, (m_owner == 0) & mq_rvalid_v);
        checkOutput({pfx, "_rvalid1"}, rq1_if.rvalid, (m_owner == 1) & mq_rvalid_v);
        checkOutput({pfx, "_done_ld0"}, rq0_if.done_ld, (m_owner == 0) & m_is_ld & mq_done_ld_v);
        checkOutput({pfx, "_done_ld1"}, rq1_if.done_ld, (m_owner == 1) & m_is_ld & mq_done_ld_v);
        checkOutput({pfx, "_done_st0"}, rq0_if.done_st, (m_owner == 0) & !m_is_ld & mq_done_st_v);
        checkOutput({pfx, "_done_st1"}, rq1_if.done_st, (m_owner == 1) & !m_is_ld & mq_done_st_v);
        checkOutput({pfx, "_rdata1"}, rq1_if.rdata, mq_rdata_v);
        checkOutput({pfx, "_mq_req"}, mq_if.req, own ? req_v[o] : 1'b0);
        checkOutput({pfx, "_mq_start"}, mq_if.start, own ? start_v[o] : 1'b0);
        checkOutput({pfx, "_mq_valid"}, mq_if.valid, own ? valid_v[o] : 1'b0);
        checkOutput({pfx, "_mq_addr"}, mq_if.addr, own ? addr_v[o] : 32'h0);
        checkOutput({pfx, "_mq_data"}, mq_if.data, own ? data_v[o] : 64'h0);
        checkOutput({pfx, "_mq_be"}, mq_if.be, own ? be_v[o] : 8'h0);
    endtask

    initial begin
        int who;
        int prev_owner;
        bit found;

        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 0, 0, 0, 32'h0, 64'h0, 8'h0);

        // Reset state
        repeat (2) @(posedge clk);
        sampleOut();
        checkOutput("rst_gnt0", rq0_if.gnt, 1'b0);
        checkOutput("rst_gnt1", rq1_if.gnt, 1'b0);
        checkOutput("rst_mq_req", mq_if.req, 1'b0);
        checkOutput("rst_mq_addr", mq_if.addr, 32'h0);
        checkOutput("rst_perf_gnt0", perf_gnt_cnt_0, 32'h0);
        checkOutput("rst_perf_wait1", perf_wait_cnt_1, 32'h0);
        tickClk();
        rst_n = 1'b1;
        tickClk();

        // Single load from requester 0
        $display("[TB] single load");
        applyStimulus(0, 1, 0, 0, 32'h1000, 64'h0, 8'h0);
        sampleOut();
        checkOutput("ld_gnt0_before", rq0_if.gnt, 1'b0);
        tickClk();
        sampleOut();
        checkOutput("ld_gnt0", rq0_if.gnt, 1'b1);
        checkOutput("ld_gnt1", rq1_if.gnt, 1'b0);
        checkOutput("ld_mq_req", mq_if.req, 1'b1);
        checkOutput("ld_mq_addr", mq_if.addr, 32'h1000);
        tickClk();
        applyStimulus(0, 0, 0, 0, 32'h1000, 64'h0, 8'h0);
        mq_rvalid_v = 1'b1;
        mq_rdata_v  = 64'hDEAD_BEEF_0000_0001;
        sampleOut();
        checkOutput("ld_rvalid0", rq0_if.rvalid, 1'b1);
        checkOutput("ld_rvalid1", rq1_if.rvalid, 1'b0);
        checkOutput("ld_rdata0", rq0_if.rdata, 64'hDEAD_BEEF_0000_0001);
        tickClk();
        mq_rvalid_v  = 1'b0;
        mq_done_ld_v = 1'b1;
        sampleOut();
        checkOutput("ld_done_ld0", rq0_if.done_ld, 1'b1);
        checkOutput("ld_done_ld1", rq1_if.done_ld, 1'b0);
        tickClk();
        mq_done_ld_v = 1'b0;
        sampleOut();
        checkOutput("ld_gnt0_after", rq0_if.gnt, 1'b0);
        checkOutput("ld_mq_req_after", mq_if.req, 1'b0);

        // Wrong-type done while requester 1 runs a load
        $display("[TB] wrong-type done");
        tickClk();
        applyStimulus(1, 1, 0, 0, 32'h2000, 64'h0, 8'h0);
        tickClk();
        applyStimulus(1, 0, 0, 0, 32'h2000, 64'h0, 8'h0);
        mq_done_st_v = 1'b1;
        sampleOut();
        checkOutput("wt_done_st0", rq0_if.done_st, 1'b0);
        checkOutput("wt_done_st1", rq1_if.done_st, 1'b0);
        checkOutput("wt_gnt1", rq1_if.gnt, 1'b1);
        tickClk();
        mq_done_st_v = 1'b0;
        sampleOut();
        checkOutput("wt_gnt1_held", rq1_if.gnt, 1'b1);
        tickClk();
        mq_done_ld_v = 1'b1;
        sampleOut();
        checkOutput("wt_done_ld1", rq1_if.done_ld, 1'b1);
        tickClk();
        mq_done_ld_v = 1'b0;
        sampleOut();
        checkOutput("wt_gnt1_after", rq1_if.gnt, 1'b0);

        // Simultaneous load (req 0) and store (req 1)
        $display("[TB] simultaneous requests");
        tickClk();
        applyStimulus(0, 1, 0, 0, 32'h3000, 64'h0, 8'h0);
        applyStimulus(1, 0, 1, 1, 32'h4000, 64'h5555_AAAA_1234_5678, 8'hFF);
        tickClk();
        sampleOut();
        checkOutput("sim_gnt0", rq0_if.gnt, 1'b1);
        checkOutput("sim_gnt1", rq1_if.gnt, 1'b0);
        tickClk();
        req_v[0]     = 1'b0;
        mq_done_ld_v = 1'b1;
        sampleOut();
        checkOutput("sim_done_ld0", rq0_if.done_ld, 1'b1);
        tickClk();
        mq_done_ld_v = 1'b0;
        sampleOut();
        checkOutput("sim_idle_gnt1", rq1_if.gnt, 1'b0);
        checkOutput("sim_idle_start", mq_if.start, 1'b0);
        tickClk();
        sampleOut();
        checkOutput("sim_gnt1", rq1_if.gnt, 1'b1);
        checkOutput("sim_mq_start", mq_if.start, 1'b1);
        checkOutput("sim_mq_be", mq_if.be, 8'hFF);
        checkOutput("sim_mq_data", mq_if.data, 64'h5555_AAAA_1234_5678);
        tickClk();
        applyStimulus(1, 0, 0, 0, 32'h0, 64'h0, 8'h0);
        mq_done_st_v = 1'b1;
        sampleOut();
        checkOutput("sim_done_st1", rq1_if.done_st, 1'b1);
        tickClk();
        mq_done_st_v = 1'b0;

        // Fairness: both hold load requests across six transactions
        $display("[TB] fairness");
        applyStimulus(0, 1, 0, 0, 32'h5000, 64'h0, 8'h0);
        applyStimulus(1, 1, 0, 0, 32'h6000, 64'h0, 8'h0);
        for (int t = 0; t < 6; t++) begin
            found = 1'b0;
            who   = -1;
            for (int k = 0; k < 6 && !found; k++) begin
                tickClk();
                sampleOut();
                if (rq0_if.gnt || rq1_if.gnt) begin
                    found = 1'b1;
                    who   = rq1_if.gnt ? 1 : 0;
                end
            end
            checkOutput("fair_grant_seen", found, 1'b1);
            checkOutput("fair_order", who, t % 2);
            tickClk();
            mq_done_ld_v = 1'b1;
            if (t == 5) begin
                req_v[0] = 1'b0;
                req_v[1] = 1'b0;
            end
            tickClk();
            mq_done_ld_v = 1'b0;
        end
        sampleOut();
        checkOutput("fair_perf_gnt0", perf_gnt_cnt_0, PERF ? 32'd5 : 32'd0);
        checkOutput("fair_perf_gnt1", perf_gnt_cnt_1, PERF ? 32'd5 : 32'd0);

        // Randomized traffic against the ownership model
        $display("[TB] random traffic");
        prev_owner = -1;
        for (int c = 0; c < 800; c++) begin
            tickClk();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev_owner == i) begin
                    req_v[i]   = 1'b0;
                    start_v[i] = 1'b0;
                    valid_v[i] = 1'($urandom_range(0, 1));
                    data_v[i]  = {$urandom, $urandom};
                    be_v[i]    = 8'($urandom);
                    addr_v[i]  = $urandom;
                end else if (!req_v[i] && !start_v[i] && ($urandom_range(0, 3) == 0)) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    applyStimulus(i, kind != 1, kind != 0, 1'($urandom_range(0, 1)),
                                  $urandom, {$urandom, $urandom}, 8'($urandom));
                end
            end
            mq_rvalid_v  = 1'($urandom_range(0, 1));
            mq_rdata_v   = {$urandom, $urandom};
            mq_done_ld_v = 1'b0;
            mq_done_st_v = 1'b0;
            if ((m_owner >= 0) && ($urandom_range(0, 3) == 0)) begin
                if ($urandom_range(0, 4) == 0) begin
                    mq_done_ld_v = !m_is_ld;
                    mq_done_st_v = m_is_ld;
                end else begin
                    mq_done_ld_v = m_is_ld;
                    mq_done_st_v = !m_is_ld;
                end
            end
            sampleOut();
            checkAgainstModel("rnd");
            prev_owner = m_owner;
        end

        // Drain any open transaction, then compare the perf counters
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 0, 0, 0, 32'h0, 64'h0, 8'h0);
        mq_rvalid_v = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mq_done_ld_v = (m_owner >= 0) && m_is_ld;
            mq_done_st_v = (m_owner >= 0) && !m_is_ld;
            tickClk();
        end
        mq_done_ld_v = 1'b0;
        mq_done_st_v = 1'b0;
        sampleOut();
        checkOutput("drain_idle", m_owner, -1);
        checkOutput("perf_gnt0", perf_gnt_cnt_0, PERF ? 64'(m_gnt[0]) : 64'h0);
        checkOutput("perf_gnt1", perf_gnt_cnt_1, PERF ? 64'(m_gnt[1]) : 64'h0);
        checkOutput("perf_wait0", perf_wait_cnt_0, PERF ? 64'(m_wait[0]) : 64'h0);
        checkOutput("perf_wait1", perf_wait_cnt_1, PERF ? 64'(m_wait[1]) : 64'h0);

        // Reset asserted mid-store
        $display("[TB] reset mid-store");
        tickClk();
        applyStimulus(1, 0, 1, 1, 32'h7000, 64'h1111_2222_3333_4444, 8'h0F);
        tickClk();
        sampleOut();
        checkOutput("rs_gnt1", rq1_if.gnt, 1'b1);
        checkOutput("rs_mq_start", mq_if.start, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rs_mq_start_rst", mq_if.start, 1'b0);
        checkOutput("rs_mq_valid_rst", mq_if.valid, 1'b0);
        checkOutput("rs_mq_addr_rst", mq_if.addr, 32'h0);
        checkOutput("rs_mq_be_rst", mq_if.be, 8'h0);
        checkOutput("rs_gnt1_rst", rq1_if.gnt, 1'b0);
        checkOutput("rs_gnt0_rst", rq0_if.gnt, 1'b0);
        applyStimulus(1, 0, 0, 0, 32'h0, 64'h0, 8'h0);
        tickClk();
        rst_n = 1'b1;
        repeat (3) tickClk();
        sampleOut();
        checkOutput("rs_idle_gnt0", rq0_if.gnt, 1'b0);
        checkOutput("rs_idle_gnt1", rq1_if.gnt, 1'b0);
        checkOutput("rs_idle_mq_req", mq_if.req, 1'b0);
        checkOutput("rs_perf_gnt1", perf_gnt_cnt_1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
